// File: rtl/timer_unit.sv
// timer_unit: two-channel 8-bit timer with shared prescaler, compare match, clear control, flags and TMO outputs
module timer_unit #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 TMCI0,
  input  logic                 TMCI1,
  input  logic                 TMRI0,
  input  logic                 TMRI1,
  input  logic [7:0]           TCR_0,
  input  logic [7:0]           TCR_1,
  input  logic [7:0]           TCSR_0,
  input  logic [7:0]           TCSR_1,
  input  logic [BIT_WIDTH-1:0] TCORA_0,
  input  logic [BIT_WIDTH-1:0] TCORA_1,
  input  logic [BIT_WIDTH-1:0] TCORB_0,
  input  logic [BIT_WIDTH-1:0] TCORB_1,
  input  logic [2:0]           FLAG_CLR_0,
  input  logic [2:0]           FLAG_CLR_1,
  output logic [BIT_WIDTH-1:0] TCNT_0,
  output logic [BIT_WIDTH-1:0] TCNT_1,
  output logic [2:0]           FLAGS_0,
  output logic [2:0]           FLAGS_1,
  output logic                 CMIA0,
  output logic                 CMIA1,
  output logic                 CMIB0,
  output logic                 CMIB1,
  output logic                 OVI0,
  output logic                 OVI1,
  output logic                 TMO0,
  output logic                 TMO1,
  output logic                 ADC_REQUEST
);
  logic [12:0] psc;
  logic [1:0] ci_s1, ci_s2, ci_h, ri_s1, ri_s2, ri_h;
  logic casc_ovf1, casc_cma0;
  logic unused;
  assign unused = ^{TCSR_0[7:5], TCSR_1[7:4]};
  function automatic logic os_out(input logic [1:0] os, input logic cur);
    return os == 2'd1 ? 1'b0 : os == 2'd2 ? 1'b1 : os == 2'd3 ? ~cur : cur;
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      psc         <= '0;
      ci_s1       <= '0;
      ci_s2       <= '0;
      ci_h        <= '0;
      ri_s1       <= '0;
      ri_s2       <= '0;
      ri_h        <= '0;
      casc_ovf1   <= 1'b0;
      casc_cma0   <= 1'b0;
      ADC_REQUEST <= 1'b0;
    end else begin
      psc         <= psc + 13'd1;
      ci_s1       <= {TMCI1, TMCI0};
      ci_s2       <= ci_s1;
      ci_h        <= ci_s2;
      ri_s1       <= {TMRI1, TMRI0};
      ri_s2       <= ri_s1;
      ri_h        <= ri_s2;
      casc_ovf1   <= g_ch[1].ev_ovf;
      casc_cma0   <= g_ch[0].ev_a;
      ADC_REQUEST <= g_ch[0].ev_a & TCSR_0[4];
    end
  end
  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic [7:0] tcr;
    logic [1:0] osa, osb, cclr;
    logic [2:0] cks, fclr, flags;
    logic [BIT_WIDTH-1:0] cora, corb, tcnt, nxt;
    logic ci_r, ci_f, ri_r, casc, tick, mclr, ext_clr, wr, ev_a, ev_b, ev_ovf, tmo;
    assign tcr     = i == 0 ? TCR_0 : TCR_1;
    assign osa     = i == 0 ? TCSR_0[1:0] : TCSR_1[1:0];
    assign osb     = i == 0 ? TCSR_0[3:2] : TCSR_1[3:2];
    assign cora    = i == 0 ? TCORA_0 : TCORA_1;
    assign corb    = i == 0 ? TCORB_0 : TCORB_1;
    assign fclr    = i == 0 ? FLAG_CLR_0 : FLAG_CLR_1;
    assign casc    = i == 0 ? casc_ovf1 : casc_cma0;
    assign cks     = tcr[2:0];
    assign cclr    = tcr[4:3];
    assign ci_r    = ci_s2[i] & ~ci_h[i];
    assign ci_f    = ~ci_s2[i] & ci_h[i];
    assign ri_r    = ri_s2[i] & ~ri_h[i];
    assign tick    = cks == 3'd1 ? &psc[2:0] :
                     cks == 3'd2 ? &psc[5:0] :
                     cks == 3'd3 ? &psc :
                     cks == 3'd4 ? casc :
                     cks == 3'd5 ? ci_r :
                     cks == 3'd6 ? ci_f :
                     cks == 3'd7 ? (ci_r | ci_f) : 1'b0;
    assign mclr    = (cclr == 2'd1 && tcnt == cora) || (cclr == 2'd2 && tcnt == corb);
    assign ext_clr = cclr == 2'd3 && ri_r;
    assign wr      = ext_clr | tick;
    assign nxt     = (ext_clr | mclr) ? '0 : tcnt + 1'b1;
    assign ev_a    = wr && nxt == cora;
    assign ev_b    = wr && nxt == corb;
    assign ev_ovf  = tick && !ext_clr && !mclr && &tcnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        tcnt  <= '0;
        flags <= '0;
        tmo   <= 1'b0;
      end else begin
        if (wr) tcnt <= nxt;
        flags <= (flags & ~fclr) | {ev_b, ev_a, ev_ovf};
        tmo   <= ev_b ? os_out(osb, tmo) : ev_a ? os_out(osa, tmo) : tmo;
      end
    end
  end
  assign TCNT_0  = g_ch[0].tcnt;
  assign TCNT_1  = g_ch[1].tcnt;
  assign FLAGS_0 = g_ch[0].flags;
  assign FLAGS_1 = g_ch[1].flags;
  assign CMIA0   = g_ch[0].flags[1] & TCR_0[6];
  assign CMIA1   = g_ch[1].flags[1] & TCR_1[6];
  assign CMIB0   = g_ch[0].flags[2] & TCR_0[7];
  assign CMIB1   = g_ch[1].flags[2] & TCR_1[7];
  assign OVI0    = g_ch[0].flags[0] & TCR_0[5];
  assign OVI1    = g_ch[1].flags[0] & TCR_1[5];
  assign TMO0    = g_ch[0].tmo;
  assign TMO1    = g_ch[1].tmo;
endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: directed self-checking bench for timer_unit
module tb_timer_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic TMCI0 = 0, TMCI1 = 0, TMRI0 = 0, TMRI1 = 0;
  logic [7:0] TCR_0 = 0, TCR_1 = 0, TCSR_0 = 0, TCSR_1 = 0;
  logic [7:0] TCORA_0 = 0, TCORA_1 = 0, TCORB_0 = 0, TCORB_1 = 0;
  logic [2:0] FLAG_CLR_0 = 0, FLAG_CLR_1 = 0;
  logic [7:0] TCNT_0, TCNT_1;
  logic [2:0] FLAGS_0, FLAGS_1;
  logic CMIA0, CMIA1, CMIB0, CMIB1, OVI0, OVI1, TMO0, TMO1, ADC_REQUEST;
  int passed = 0, total = 0;
  logic [7:0] exp_cnt [8] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
  logic       exp_tmo [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  timer_unit #(.BIT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .TMCI0(TMCI0), .TMCI1(TMCI1), .TMRI0(TMRI0), .TMRI1(TMRI1),
    .TCR_0(TCR_0), .TCR_1(TCR_1), .TCSR_0(TCSR_0), .TCSR_1(TCSR_1),
    .TCORA_0(TCORA_0), .TCORA_1(TCORA_1), .TCORB_0(TCORB_0), .TCORB_1(TCORB_1),
    .FLAG_CLR_0(FLAG_CLR_0), .FLAG_CLR_1(FLAG_CLR_1),
    .TCNT_0(TCNT_0), .TCNT_1(TCNT_1), .FLAGS_0(FLAGS_0), .FLAGS_1(FLAGS_1),
    .CMIA0(CMIA0), .CMIA1(CMIA1), .CMIB0(CMIB0), .CMIB1(CMIB1),
    .OVI0(OVI0), .OVI1(OVI1), .TMO0(TMO0), .TMO1(TMO1), .ADC_REQUEST(ADC_REQUEST)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask
  task automatic pulse0();
    TMCI0 = 1'b1;
    step(2);
    TMCI0 = 1'b0;
    step(2);
  endtask
  initial begin
    // clk/8 free count, OVIE on ch0 only
    TCR_0 = 8'h21;
    TCR_1 = 8'h01;
    TCORA_0 = 8'h80;
    TCORA_1 = 8'h80;
    do_reset();
    chk("rst_tcnt0", TCNT_0, 8'h00);
    chk("rst_flags0", FLAGS_0, 3'b000);
    chk("rst_tmo0", TMO0, 1'b0);
    chk("rst_adc", ADC_REQUEST, 1'b0);
    chk("rst_ovi0", OVI0, 1'b0);
    step(7);
    chk("div8_before", TCNT_0, 8'h00);
    step(1);
    chk("div8_first", TCNT_0, 8'h01);
    step(8);
    chk("div8_second", TCNT_0, 8'h02);
    step(2047 - 16);
    chk("div8_ff", TCNT_0, 8'hFF);
    chk("div8_no_ovf", FLAGS_0[0], 1'b0);
    step(1);
    chk("wrap_tcnt0", TCNT_0, 8'h00);
    chk("wrap_ovf0", FLAGS_0[0], 1'b1);
    chk("wrap_ovi0", OVI0, 1'b1);
    chk("wrap_ovf1", FLAGS_1[0], 1'b1);
    chk("wrap_ovi1_masked", OVI1, 1'b0);
    // mid-operation reset
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rerst_flags0", FLAGS_0, 3'b000);
    chk("rerst_tcnt1", TCNT_1, 8'h00);
    // clear on match A with toggle, TMCI rising edges
    TCR_0 = 8'h0D;
    TCR_1 = 8'h00;
    TCORA_0 = 8'h03;
    TCSR_0 = 8'h03;
    do_reset();
    TMCI0 = 1'b1;
    step(2);
    chk("ext_latency_early", TCNT_0, 8'h00);
    step(1);
    chk("ext_latency_k2", TCNT_0, 8'h01);
    TMCI0 = 1'b0;
    step(3);
    chk("no_fall_tick", TCNT_0, 8'h01);
    for (int p = 1; p < 8; p++) begin
      pulse0();
      chk($sformatf("mclr_tcnt_%0d", p), TCNT_0, exp_cnt[p]);
      chk($sformatf("mclr_tmo_%0d", p), TMO0, exp_tmo[p]);
      if (p == 2) chk("mclr_cmfa", FLAGS_0[1], 1'b1);
    end
    // simultaneous A/B match, OS_B wins
    TCR_0 = 8'h45;
    TCORA_0 = 8'h05;
    TCORB_0 = 8'h05;
    TCSR_0 = 8'h06;
    do_reset();
    repeat (4) pulse0();
    chk("ab_pre_flags", FLAGS_0, 3'b000);
    pulse0();
    chk("ab_tcnt", TCNT_0, 8'h05);
    chk("ab_tmo_b_wins", TMO0, 1'b0);
    chk("ab_flags", FLAGS_0, 3'b110);
    chk("ab_cmia", CMIA0, 1'b1);
    chk("ab_cmib_masked", CMIB0, 1'b0);
    // flag clear vs simultaneous set
    FLAG_CLR_0 = 3'b111;
    step(1);
    FLAG_CLR_0 = 3'b000;
    chk("clr_all", FLAGS_0, 3'b000);
    TCORA_0 = 8'h07;
    pulse0();
    chk("fc_tcnt6", TCNT_0, 8'h06);
    TMCI0 = 1'b1;
    step(2);
    FLAG_CLR_0 = 3'b010;
    step(1);
    FLAG_CLR_0 = 3'b000;
    chk("fc_tcnt7", TCNT_0, 8'h07);
    chk("fc_set_wins", FLAGS_0[1], 1'b1);
    chk("fc_cmia_on", CMIA0, 1'b1);
    TMCI0 = 1'b0;
    FLAG_CLR_0 = 3'b010;
    step(1);
    FLAG_CLR_0 = 3'b000;
    chk("fc_cleared", FLAGS_0[1], 1'b0);
    chk("fc_cmia_off", CMIA0, 1'b0);
    // TMRI external clear
    TCR_0 = 8'h1D;
    TCORA_0 = 8'h00;
    TCORB_0 = 8'h00;
    TCSR_0 = 8'h00;
    do_reset();
    repeat (64) begin
      TMCI0 = 1'b1;
      step(1);
      TMCI0 = 1'b0;
      step(1);
    end
    step(3);
    chk("tmri_pre", TCNT_0, 8'h40);
    TMRI0 = 1'b1;
    step(2);
    chk("tmri_early", TCNT_0, 8'h40);
    step(1);
    chk("tmri_clear", TCNT_0, 8'h00);
    TMRI0 = 1'b0;
    step(3);
    chk("tmri_fall_noop", TCNT_0, 8'h00);
    // cascade: ch1 counts ch0 match-A events, ADC pulses
    TCR_0 = 8'h09;
    TCR_1 = 8'h04;
    TCORA_0 = 8'h01;
    TCORB_0 = 8'hFF;
    TCORA_1 = 8'hFF;
    TCORB_1 = 8'hFF;
    TCSR_0 = 8'h10;
    do_reset();
    step(7);
    chk("casc_adc_idle", ADC_REQUEST, 1'b0);
    step(1);
    chk("casc_tcnt0_match", TCNT_0, 8'h01);
    chk("casc_adc_1", ADC_REQUEST, 1'b1);
    chk("casc_tcnt1_lag", TCNT_1, 8'h00);
    step(1);
    chk("casc_adc_end_1", ADC_REQUEST, 1'b0);
    chk("casc_tcnt1_1", TCNT_1, 8'h01);
    step(7);
    chk("casc_tcnt0_clr", TCNT_0, 8'h00);
    chk("casc_nomatch_adc", ADC_REQUEST, 1'b0);
    step(8);
    chk("casc_adc_2", ADC_REQUEST, 1'b1);
    chk("casc_tcnt1_hold", TCNT_1, 8'h01);
    step(1);
    chk("casc_tcnt1_2", TCNT_1, 8'h02);
    chk("casc_adc_end_2", ADC_REQUEST, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
